// File: rtl/div20_iter.sv
// Iterative 20-bit unsigned restoring divider: one quotient bit per clock, MSB first.
// Trial subtractions go through the shared 20-bit subtraction unit div20_sub.

module div20_sub (
   input  logic [19:0] a,
   input  logic [19:0] b,
   output logic [19:0] out,
   output logic        cout
);
   logic [20:0] diff;

   assign diff = {1'b0, a} - {1'b0, b};
   assign out  = diff[19:0];
   assign cout = diff[20];
endmodule

module div20_iter (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [19:0] dividend,
   input  logic [19:0] divisor,
   output logic        busy,
   output logic        done,
   output logic [19:0] quotient,
   output logic [19:0] remainder,
   output logic        div_by_zero
);
   localparam int unsigned W     = 20;
   localparam int unsigned CNT_W = 5;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t             state_q, state_d;
   logic [W-1:0]       wq_q, wq_d;
   logic [W-1:0]       dvs_q, dvs_d;
   logic [W-1:0]       rem_q, rem_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic [W-1:0]       quot_q, quot_d;
   logic [W-1:0]       remo_q, remo_d;
   logic               dbz_q, dbz_d;

   logic [W:0]         rs;
   logic [W-1:0]       trial;
   logic               borrow;
   logic               accept;
   logic [W:0]         rem_next;

   // Bit 20 of the partial remainder is always 0 after a step (either a
   // subtraction result or a rejected Rs that is below the divisor), so only
   // the low 20 bits are stored; the overflow bit lives only in Rs.
   assign rs = {rem_q, wq_q[W-1]};

   div20_sub u_sub (
      .a    (rs[W-1:0]),
      .b    (dvs_q),
      .out  (trial),
      .cout (borrow)
   );

   assign accept   = rs[W] | ~borrow;
   assign rem_next = accept ? {1'b0, trial} : rs;

   always_comb begin
      state_d = state_q;
      wq_d    = wq_q;
      dvs_d   = dvs_q;
      rem_d   = rem_q;
      cnt_d   = cnt_q;
      quot_d  = quot_q;
      remo_d  = remo_q;
      dbz_d   = dbz_q;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               wq_d  = dividend;
               dvs_d = divisor;
               rem_d = '0;
               cnt_d = '0;
               if (divisor != '0) begin
                  state_d = S_RUN;
               end else begin
                  state_d = S_DONE;
                  quot_d  = '1;
                  remo_d  = dividend;
                  dbz_d   = 1'b1;
               end
            end
         end
         S_RUN: begin
            wq_d  = {wq_q[W-2:0], accept};
            rem_d = rem_next[W-1:0];
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(W - 1)) begin
               state_d = S_DONE;
               quot_d  = {wq_q[W-2:0], accept};
               remo_d  = rem_next[W-1:0];
               dbz_d   = 1'b0;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      busy_d = (state_d != S_IDLE);
      done_d = (state_d == S_DONE);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         wq_q    <= '0;
         dvs_q   <= '0;
         rem_q   <= '0;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         quot_q  <= '0;
         remo_q  <= '0;
         dbz_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         wq_q    <= wq_d;
         dvs_q   <= dvs_d;
         rem_q   <= rem_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         quot_q  <= quot_d;
         remo_q  <= remo_d;
         dbz_q   <= dbz_d;
      end
   end

   assign busy        = busy_q;
   assign done        = done_q;
   assign quotient    = quot_q;
   assign remainder   = remo_q;
   assign div_by_zero = dbz_q;
endmodule
